// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 12-hour time-of-day counter with second prescaler and load from the setting stage
module time_keeper #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] inHours,
    input  logic [5:0] inMinutes,
    input  logic       inPM,
    input  logic       pause,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       isPM,
    output logic       secTick,
    output logic       minTick,
    output logic       loadErr
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          pm_q, pm_d;
    logic          sec_tick_q, sec_tick_d;
    logic          min_tick_q, min_tick_d;
    logic          load_err_q, load_err_d;

    logic load_legal;
    logic load_ok;
    logic sec_due;
    logic sec_wrap;
    logic min_wrap;

    // A rejected load must not disturb counting, so only a legal load takes priority.
    assign load_legal = (inHours >= 4'd1) && (inHours <= 4'd12) && (inMinutes <= 6'd59);
    assign load_ok    = load && load_legal;
    assign sec_due    = !pause && (presc_q == PRESC_LAST);
    assign sec_wrap   = (sec_q == 6'd59);
    assign min_wrap   = (min_q == 6'd59);

    always_comb begin
        presc_d    = presc_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        pm_d       = pm_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        load_err_d = load && !load_legal;

        if (load_ok) begin
            hour_d     = inHours;
            min_d      = inMinutes;
            pm_d       = inPM;
            sec_d      = 6'd0;
            presc_d    = '0;
            min_tick_d = 1'b1;
        end else if (!pause) begin
            if (sec_due) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (sec_wrap) begin
                    sec_d      = 6'd0;
                    min_tick_d = 1'b1;
                    if (min_wrap) begin
                        min_d = 6'd0;
                        // 11 -> 12 is where the meridiem flips; 12 -> 1 keeps it.
                        if (hour_q == 4'd11) begin
                            hour_d = 4'd12;
                            pm_d   = !pm_q;
                        end else if (hour_q == 4'd12) begin
                            hour_d = 4'd1;
                        end else begin
                            hour_d = hour_q + 4'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            hour_q     <= 4'd12;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            pm_q       <= pm_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign hours   = hour_q;
    assign minutes = min_q;
    assign seconds = sec_q;
    assign isPM    = pm_q;
    assign secTick = sec_tick_q;
    assign minTick = min_tick_q;
    assign loadErr = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed and randomized checks of time_keeper against a seconds-of-day model
module tb_time_keeper;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] inHours = 4'd0;
    logic [5:0] inMinutes = 6'd0;
    logic       inPM = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       isPM;
    logic       secTick;
    logic       minTick;
    logic       loadErr;

    int vectors = 0;
    int miscompares = 0;

    // Model: time as seconds since midnight on a 24-hour day, plus a prescaler count.
    int m_tod = 0;
    int m_presc = 0;
    bit e_sec = 0;
    bit e_min = 0;
    bit e_err = 0;

    time_keeper #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .reset(reset), .load(load), .inHours(inHours),
        .inMinutes(inMinutes), .inPM(inPM), .pause(pause),
        .hours(hours), .minutes(minutes), .seconds(seconds), .isPM(isPM),
        .secTick(secTick), .minTick(minTick), .loadErr(loadErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int e_hours();
        int h;
        h = (m_tod / 3600) % 12;
        return (h == 0) ? 12 : h;
    endfunction

    task automatic model_edge();
        int legal;
        e_sec = 0;
        e_min = 0;
        e_err = 0;
        if (reset) begin
            m_tod = 0;
            m_presc = 0;
        end else begin
            legal = (inHours >= 1 && inHours <= 12 && inMinutes <= 59) ? 1 : 0;
            e_err = load && !legal;
            if (load && legal) begin
                m_tod = ((int'(inHours) % 12) + (inPM ? 12 : 0)) * 3600 + int'(inMinutes) * 60;
                m_presc = 0;
                e_min = 1;
            end else if (!pause) begin
                if (m_presc == T - 1) begin
                    m_presc = 0;
                    m_tod = (m_tod + 1) % 86400;
                    e_sec = 1;
                    e_min = (m_tod % 60) == 0;
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("hours", 32'(hours), 32'(e_hours()));
        chk("minutes", 32'(minutes), 32'((m_tod / 60) % 60));
        chk("seconds", 32'(seconds), 32'(m_tod % 60));
        chk("isPM", 32'(isPM), 32'(m_tod >= 43200));
        chk("secTick", 32'(secTick), 32'(e_sec));
        chk("minTick", 32'(minTick), 32'(e_min));
        chk("loadErr", 32'(loadErr), 32'(e_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int h, input int m, input bit pm);
        load = 1'b1;
        inHours = 4'(h);
        inMinutes = 6'(m);
        inPM = pm;
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset and first second
        reset = 1'b1;
        run(2);
        chk("rst_hours", 32'(hours), 32'd12);
        chk("rst_pm", 32'(isPM), 32'd0);
        chk("rst_sec", 32'(seconds), 32'd0);
        reset = 1'b0;
        run(3);
        chk("first_sec_early", 32'(secTick), 32'd0);
        step();
        chk("first_sec", 32'(seconds), 32'd1);
        chk("first_tick", 32'(secTick), 32'd1);
        step();
        chk("first_tick_width", 32'(secTick), 32'd0);

        // 11:59 AM -> 12:00:00 PM
        do_load(11, 59, 1'b0);
        run(59 * T);
        chk("am_pm_pre_sec", 32'(seconds), 32'd59);
        run(T);
        chk("am_pm_hours", 32'(hours), 32'd12);
        chk("am_pm_pm", 32'(isPM), 32'd1);
        chk("am_pm_mintick", 32'(minTick), 32'd1);

        // 12:59 PM -> 1:00:00 PM
        do_load(12, 59, 1'b1);
        run(60 * T);
        chk("h12_1_hours", 32'(hours), 32'd1);
        chk("h12_1_pm", 32'(isPM), 32'd1);

        // 11:59 PM -> 12:00:00 AM
        do_load(11, 59, 1'b1);
        run(60 * T);
        chk("pm_am_hours", 32'(hours), 32'd12);
        chk("pm_am_pm", 32'(isPM), 32'd0);

        // Load while a second advance is due
        do_load(4, 10, 1'b0);
        run(42 * T + 3);
        chk("pre_load_sec", 32'(seconds), 32'd42);
        do_load(7, 30, 1'b1);
        chk("ld_due_sectick", 32'(secTick), 32'd0);
        chk("ld_due_mintick", 32'(minTick), 32'd1);
        chk("ld_due_min", 32'(minutes), 32'd30);
        run(T - 1);
        step();
        chk("ld_next_tick", 32'(secTick), 32'd1);

        // Illegal loads
        do_load(13, 5, 1'b0);
        chk("bad_h13", 32'(loadErr), 32'd1);
        do_load(0, 5, 1'b1);
        chk("bad_h0", 32'(loadErr), 32'd1);
        do_load(5, 60, 1'b0);
        chk("bad_m60", 32'(loadErr), 32'd1);
        chk("bad_m60_hours", 32'(hours), 32'd7);
        run(2 * T);

        // Pause with a load in the middle, then resume
        run(2);
        pause = 1'b1;
        run(5);
        do_load(3, 15, 1'b0);
        chk("pause_load_h", 32'(hours), 32'd3);
        run(4);
        pause = 1'b0;
        run(3 * T);

        // Reset together with a load
        load = 1'b1;
        inHours = 4'd9;
        inMinutes = 6'd9;
        reset = 1'b1;
        step();
        chk("rst_ld_hours", 32'(hours), 32'd12);
        load = 1'b0;
        reset = 1'b0;
        run(T);

        // Randomized traffic biased towards minute/hour boundaries
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            pause = ($urandom_range(0, 9) == 0) ? ~pause : pause;
            load = ($urandom_range(0, 29) == 0);
            inHours = 4'($urandom_range(0, 15));
            inMinutes = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(57, 63))
                                                     : 6'($urandom_range(0, 63));
            inPM = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
